// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, unsigned or two's-complement.
// The last signed step subtracts the multiplicand because the multiplier's MSB carries negative weight.
module seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               x_q, x_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0] extA;
  logic [WIDTH:0] extM;
  logic [WIDTH:0] sumVal;
  logic           lastStep;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      x_q       <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      x_q       <= x_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    x_d       = x_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    extA      = {mode_q & a_q[WIDTH-1], a_q};
    extM      = {mode_q & m_q[WIDTH-1], m_q};
    sumVal    = {x_q, a_q};
    lastStep  = (cnt_q == CW'(WIDTH - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a_in;
          q_d     = b_in;
          mode_d  = is_signed;
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (q_q[0]) begin
          sumVal = (mode_q && lastStep) ? (extA - extM) : (extA + extM);
        end
        // Unsigned keeps the adder carry as the new A MSB and shifts a zero into X.
        x_d   = mode_q ? sumVal[WIDTH] : 1'b0;
        a_d   = sumVal[WIDTH:1];
        q_d   = {sumVal[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (lastStep) begin
          product_d = {a_d, q_d};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// Bench for seq_mult_n: directed W=8 vectors plus free-running random instances at W=4 and W=16.
// A per-instance timing/arithmetic model is compared against every instance on every cycle.
module tb_seq_mult_n;

  logic       clock;
  logic       reset;
  logic       start;
  logic       isSigned;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       randOn;
  logic       checkOn;

  logic        busyV    [3];
  logic        doneV    [3];
  logic [63:0] productV [3];

  int total = 0;
  int bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, reduced to 2*w bits.
  function automatic logic [63:0] refProd(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int w);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gInst
    localparam int WL = (g == 0) ? 8 : ((g == 1) ? 4 : 16);

    logic              st;
    logic              sg;
    logic [WL-1:0]     a;
    logic [WL-1:0]     b;
    logic              bz;
    logic              dn;
    logic [2*WL-1:0]   pr;

    if (g == 0) begin : gMain
      assign st = start;
      assign sg = isSigned;
      assign a  = aIn;
      assign b  = bIn;
    end else begin : gRand
      logic          rs;
      logic          rsg;
      logic [WL-1:0] ra;
      logic [WL-1:0] rb;
      initial begin
        rs = 1'b0; rsg = 1'b0; ra = '0; rb = '0;
        forever begin
          @(negedge clock);
          rs  = randOn && ($urandom_range(0, 3) != 0);
          rsg = 1'($urandom);
          ra  = WL'($urandom);
          rb  = WL'($urandom);
        end
      end
      assign st = rs;
      assign sg = rsg;
      assign a  = ra;
      assign b  = rb;
    end

    seq_mult_n #(.WIDTH(WL)) dut (
      .Clk      (clock),
      .Reset    (reset),
      .start    (st),
      .is_signed(sg),
      .a_in     (a),
      .b_in     (b),
      .busy     (bz),
      .done     (dn),
      .product  (pr)
    );

    assign busyV[g]    = bz;
    assign doneV[g]    = dn;
    assign productV[g] = 64'(pr);

    // phase 0 = idle, 1..WL = multiply steps, WL+1 = result cycle.
    int          phase = 0;
    logic [63:0] pend  = '0;
    logic [63:0] expP  = '0;

    always @(posedge clock) begin
      if (reset) begin
        phase <= 0;
        expP  <= '0;
      end else if (phase == 0) begin
        if (st) begin
          pend  <= refProd(64'(a), 64'(b), sg, WL);
          phase <= 1;
        end
      end else if (phase == WL) begin
        expP  <= pend;
        phase <= WL + 1;
      end else if (phase == WL + 1) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
      end
    end

    always @(negedge clock) begin
      if (checkOn) begin
        checkOutput($sformatf("w%0d_busy", WL), 64'(bz), 64'(phase >= 1 && phase <= WL));
        checkOutput($sformatf("w%0d_done", WL), 64'(dn), 64'(phase == WL + 1));
        checkOutput($sformatf("w%0d_product", WL), 64'(pr), expP);
        checkOutput($sformatf("w%0d_busy_and_done", WL), 64'(bz & dn), 64'd0);
      end
    end
  end

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                               input logic [15:0] expP, input string nm);
    int lat;
    start = 1'b1; isSigned = s; aIn = av; bIn = bv;
    @(negedge clock);
    start = 1'b0;
    aIn = 8'($urandom); bIn = 8'($urandom); isSigned = ~s;
    lat = 1;
    while (!doneV[0] && lat < 40) begin
      @(negedge clock);
      aIn = 8'($urandom); bIn = 8'($urandom);
      lat++;
    end
    checkOutput({nm, "_latency"}, 64'(lat), 64'd9);
    checkOutput({nm, "_product"}, productV[0], 64'(expP));
    @(negedge clock);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busyV[0] || doneV[0]) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_idle", 64'(n < 50), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones;
    logic s;
    logic [7:0] ra;
    logic [7:0] rb;
    reset = 1'b1; start = 1'b0; isSigned = 1'b0; aIn = '0; bIn = '0;
    randOn = 1'b0; checkOn = 1'b0;
    repeat (3) @(negedge clock);
    checkOn = 1'b1;
    checkOutput("reset_busy", 64'(busyV[0]), 64'd0);
    checkOutput("reset_done", 64'(doneV[0]), 64'd0);
    checkOutput("reset_product", productV[0], 64'd0);

    // First start is applied together with reset release.
    reset = 1'b0;
    randOn = 1'b1;
    applyStimulus(1'b1, 8'h07, 8'hFD, 16'hFFEB, "s_7x-3");
    applyStimulus(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff");
    applyStimulus(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_-1x-1");
    applyStimulus(1'b1, 8'h80, 8'h80, 16'h4000, "s_minxmin");
    applyStimulus(1'b1, 8'h80, 8'h7F, 16'hC080, "s_minxmax");
    applyStimulus(1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_maxxmax");
    applyStimulus(1'b0, 8'h0C, 8'h0A, 16'h0078, "u_12x10");
    applyStimulus(1'b0, 8'h00, 8'hA5, 16'h0000, "u_zero");

    // Start held high with operands changing every cycle.
    dones = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      isSigned = 1'($urandom); aIn = 8'($urandom); bIn = 8'($urandom);
      @(negedge clock);
      if (doneV[0]) dones++;
    end
    start = 1'b0;
    checkOutput("b2b_done_count", 64'(dones), 64'd3);
    waitIdle();

    // Abort a multiply in its fourth step.
    start = 1'b1; isSigned = 1'b0; aIn = 8'h33; bIn = 8'h44;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("abort_busy_before", 64'(busyV[0]), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busyV[0]), 64'd0);
    checkOutput("abort_done", 64'(doneV[0]), 64'd0);
    checkOutput("abort_product", productV[0], 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (doneV[0]) dones++;
    end
    checkOutput("abort_no_done", 64'(dones), 64'd0);
    applyStimulus(1'b1, 8'h07, 8'hFD, 16'hFFEB, "after_abort");

    for (int i = 0; i < 16; i++) begin
      s  = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(s, ra, rb, 16'(refProd(64'(ra), 64'(rb), s, 8)), "rand8");
    end

    randOn = 1'b0;
    repeat (40) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
